// File: rtl/frame_filler.sv
// Framebuffer clear engine: streams one full-word colour write per pixel to the memory bypass port.
// Optional FILL-cycle performance counter enabled by defining FRAME_FILLER_PERF_EN.
module frame_filler #(
  parameter logic [31:0] FB_BASE     = 32'h1000_0000,
  parameter int unsigned FB_WIDTH    = 800,
  parameter int unsigned FB_HEIGHT   = 600,
  parameter int unsigned STRIDE_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] filler_color,
  input  logic        filler_valid,
  output logic        filler_ready,
  output logic [31:0] bypass_addr,
  output logic [31:0] bypass_din,
  output logic [3:0]  bypass_we,
  output logic        bypass_valid,
  input  logic        bypass_ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] fill_cycles
);

  localparam int unsigned XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int unsigned YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic          last_pix;

  // Byte address of pixel (xv, yv); 32-bit arithmetic that wraps silently.
  function automatic logic [31:0] pix_addr(input logic [XW-1:0] xv, input logic [YW-1:0] yv);
    logic [31:0] word;
    word = (32'(yv) << STRIDE_LOG2) + 32'(xv);
    return FB_BASE + (word << 2);
  endfunction

  always_comb begin
    x_next   = x;
    y_next   = y;
    last_pix = 1'b0;
    if (x != X_LAST) begin
      x_next = x + XW'(1);
    end else begin
      x_next = '0;
      if (y != Y_LAST) y_next = y + YW'(1);
      else             last_pix = 1'b1;
    end
  end

  // done is raised on the DONE->IDLE edge so it appears together with filler_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      filler_ready <= 1'b1;
      bypass_addr  <= '0;
      bypass_din   <= '0;
      bypass_we    <= '0;
      bypass_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (filler_valid && filler_ready) begin
            state        <= FILL;
            x            <= '0;
            y            <= '0;
            filler_ready <= 1'b0;
            busy         <= 1'b1;
            bypass_valid <= 1'b1;
            bypass_we    <= '1;
            bypass_din   <= {8'h00, filler_color};
            bypass_addr  <= pix_addr('0, '0);
          end
        end
        FILL: begin
          if (bypass_ack) begin
            x <= x_next;
            y <= y_next;
            if (last_pix) begin
              state        <= DONE;
              bypass_valid <= 1'b0;
              bypass_we    <= '0;
              busy         <= 1'b0;
            end else begin
              bypass_addr <= pix_addr(x_next, y_next);
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          done         <= 1'b1;
          filler_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_FILLER_PERF_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && filler_valid && filler_ready) begin
      cycle_cnt <= '0;
    end else if (state == FILL && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign fill_cycles = cycle_cnt;
`else
  assign fill_cycles = '0;
`endif

endmodule

// File: tb/tb_frame_filler.sv
// Randomised self-checking bench for frame_filler: small 4x2 frame plus an 800-wide, 3-row instance.
module tb_frame_filler;

  localparam logic [31:0] T_BASE = 32'h0;
  localparam int unsigned T_W = 4;
  localparam int unsigned T_H = 2;
  localparam int unsigned T_S = 3;

  localparam logic [31:0] W_BASE = 32'h1000_0000;
  localparam int unsigned W_W = 800;
  localparam int unsigned W_H = 3;
  localparam int unsigned W_S = 10;

  logic        clk;
  logic        rst_n;
  logic [23:0] filler_color;
  logic        filler_valid;
  logic        filler_ready;
  logic [31:0] bypass_addr;
  logic [31:0] bypass_din;
  logic [3:0]  bypass_we;
  logic        bypass_valid;
  logic        bypass_ack;
  logic        busy;
  logic        done;
  logic [31:0] fill_cycles;

  logic [23:0] w_color;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_addr;
  logic [31:0] w_din;
  logic [3:0]  w_we;
  logic        w_bvalid;
  logic        w_ack;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_fill_cycles;

  int unsigned n_checks;
  int unsigned n_fail;

  frame_filler #(
    .FB_BASE    (T_BASE),
    .FB_WIDTH   (T_W),
    .FB_HEIGHT  (T_H),
    .STRIDE_LOG2(T_S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .filler_color(filler_color),
    .filler_valid(filler_valid),
    .filler_ready(filler_ready),
    .bypass_addr (bypass_addr),
    .bypass_din  (bypass_din),
    .bypass_we   (bypass_we),
    .bypass_valid(bypass_valid),
    .bypass_ack  (bypass_ack),
    .busy        (busy),
    .done        (done),
    .fill_cycles (fill_cycles)
  );

  frame_filler #(
    .FB_BASE    (W_BASE),
    .FB_WIDTH   (W_W),
    .FB_HEIGHT  (W_H),
    .STRIDE_LOG2(W_S)
  ) dut_wide (
    .clk         (clk),
    .rst_n       (rst_n),
    .filler_color(w_color),
    .filler_valid(w_valid),
    .filler_ready(w_ready),
    .bypass_addr (w_addr),
    .bypass_din  (w_din),
    .bypass_we   (w_we),
    .bypass_valid(w_bvalid),
    .bypass_ack  (w_ack),
    .busy        (w_busy),
    .done        (w_done),
    .fill_cycles (w_fill_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k-th pixel in raster order lands at row k/W, column k%W of a 2**S-word stride.
  function automatic logic [31:0] exp_addr(input int unsigned k);
    return T_BASE + 32'(((k / T_W) * (2 ** T_S) + (k % T_W)) * 4);
  endfunction

  function automatic logic [31:0] exp_addr_wide(input int unsigned k);
    return W_BASE + 32'(((k / W_W) * (2 ** W_S) + (k % W_W)) * 4);
  endfunction

  function automatic logic [31:0] exp_perf(input int unsigned fill_len);
`ifdef FRAME_FILLER_PERF_EN
    return 32'(fill_len);
`else
    return 32'(fill_len) & 32'h0;
`endif
  endfunction

  // ack_mode: 1 = every cycle, 3 = every third cycle, otherwise random.
  task automatic do_fill(input logic [23:0] col, input int unsigned ack_mode,
                         input bit intrude, input bit pre_accepted);
    int unsigned cyc;
    int unsigned writes;
    int unsigned last_ack;
    bit prev_stall;
    bit got_done;
    logic [31:0] prev_addr;
    logic [31:0] prev_din;
    cyc = 0; writes = 0; last_ack = 0; prev_stall = 0; got_done = 0;
    prev_addr = '0; prev_din = '0;
    if (!pre_accepted) begin
      @(posedge clk); #1;
      bypass_ack = 1'b0;
      filler_color = col;
      filler_valid = 1'b1;
      @(negedge clk);
      check("ready_idle", filler_ready, 1'b1);
      check("busy_idle", busy, 1'b0);
    end
    @(posedge clk); #1;
    filler_valid = 1'b0;
    filler_color = 24'($urandom);
    while (!got_done && cyc < 4000) begin
      cyc++;
      case (ack_mode)
        1:       bypass_ack = 1'b1;
        3:       bypass_ack = (cyc % 3 == 0);
        default: bypass_ack = ($urandom_range(0, 3) != 0);
      endcase
      if (intrude && cyc >= 3) begin
        filler_valid = 1'b1;
        filler_color = 24'hFF0000;
      end
      @(negedge clk);
      if (cyc == 1) begin
        check("first_valid", bypass_valid, 1'b1);
        check("done_low_start", done, 1'b0);
      end
      if (bypass_valid) begin
        check("busy_fill", busy, 1'b1);
        check("we", bypass_we, 4'hF);
        check("din", bypass_din, {8'h00, col});
        if (prev_stall) begin
          check("hold_addr", bypass_addr, prev_addr);
          check("hold_din", bypass_din, prev_din);
        end
        if (bypass_ack) begin
          if (writes < T_W * T_H) check("addr", bypass_addr, exp_addr(writes));
          else                    check("extra_write", writes, T_W * T_H);
          writes++;
          last_ack = cyc;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_addr = bypass_addr;
          prev_din = bypass_din;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (intrude && cyc >= 3 && !done) check("ready_busy", filler_ready, 1'b0);
      if (done) begin
        got_done = 1'b1;
        check("write_count", writes, T_W * T_H);
        check("done_after_last_ack", cyc, last_ack + 2);
        if (ack_mode == 1) check("done_latency", cyc, T_W * T_H + 2);
        check("ready_at_done", filler_ready, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("valid_at_done", bypass_valid, 1'b0);
        check("fill_cycles", fill_cycles, exp_perf(last_ack));
      end else if (cyc < 4000) begin
        @(posedge clk); #1;
      end
    end
    if (!got_done) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic wide_fill(input logic [23:0] col);
    int unsigned cyc;
    int unsigned writes;
    logic [31:0] last_addr;
    bit got_done;
    cyc = 0; writes = 0; last_addr = '0; got_done = 0;
    @(posedge clk); #1;
    w_color = col;
    w_valid = 1'b1;
    w_ack = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    while (!got_done && cyc < 3000) begin
      cyc++;
      @(negedge clk);
      if (w_bvalid && w_ack) begin
        if (writes < W_W * W_H) check("wide_addr", w_addr, exp_addr_wide(writes));
        else                    check("wide_extra", writes, W_W * W_H);
        check("wide_din", w_din, {8'h00, col});
        last_addr = w_addr;
        writes++;
      end
      if (w_done) begin
        got_done = 1'b1;
        check("wide_count", writes, W_W * W_H);
        check("wide_last_addr", last_addr, 32'h1000_2C7C);
        check("wide_latency", cyc, W_W * W_H + 2);
      end
    end
    if (!got_done) check("wide_timeout", 1'b0, 1'b1);
    w_ack = 1'b0;
  endtask

  initial begin
    int unsigned acks;
    int unsigned guard;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    filler_color = '0;
    filler_valid = 1'b0;
    bypass_ack = 1'b0;
    w_color = '0;
    w_valid = 1'b0;
    w_ack = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", filler_ready, 1'b1);
    check("rst_valid", bypass_valid, 1'b0);
    check("rst_we", bypass_we, 4'h0);
    check("rst_addr", bypass_addr, 32'h0);
    check("rst_din", bypass_din, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fill_cycles", fill_cycles, 32'h0);
    rst_n = 1'b1;

    do_fill(24'h12_34_56, 1, 1'b0, 1'b0);
    do_fill(24'($urandom), 3, 1'b0, 1'b0);

    // A request held during a fill is taken only once the block is idle again.
    do_fill(24'hA5_5A_3C, 1, 1'b1, 1'b0);
    do_fill(24'hFF_00_00, 1, 1'b0, 1'b1);

    @(posedge clk); #1;
    bypass_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_valid", bypass_valid, 1'b0);
      check("spur_busy", busy, 1'b0);
      check("spur_ready", filler_ready, 1'b1);
      check("spur_done", done, 1'b0);
    end
    bypass_ack = 1'b0;
    do_fill(24'($urandom), 1, 1'b0, 1'b0);

    @(posedge clk); #1;
    filler_color = 24'h0F_0F_0F;
    filler_valid = 1'b1;
    @(posedge clk); #1;
    filler_valid = 1'b0;
    bypass_ack = 1'b1;
    acks = 0;
    guard = 0;
    while (acks < 3 && guard < 50) begin
      guard++;
      @(negedge clk);
      if (bypass_valid && bypass_ack) acks++;
    end
    check("reset_setup_acks", acks, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", bypass_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", filler_ready, 1'b1);
    check("abort_we", bypass_we, 4'h0);
    check("abort_fill_cycles", fill_cycles, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    bypass_ack = 1'b0;
    @(negedge clk);
    check("post_reset_done", done, 1'b0);
    do_fill(24'h00_FF_00, 1, 1'b0, 1'b0);

    repeat (4) do_fill(24'($urandom), 0, 1'b0, 1'b0);

    wide_fill(24'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
